pipewbrf: RTL and testbench
===========================

# pipewbrf

Writeback-stage block that sits at the consumer end of the MEM/WB pipeline register. It selects the writeback value (memory data or ALU result), commits it to a 32 x 32-bit general register file, and serves the two ID-stage read ports. It supplies same-cycle write-to-read bypass so ID never reads stale data for the instruction in WB, and it keeps a retired-writeback counter for performance monitoring.

## Interface

Parameters:
- BYPASS, default 1: 1 = same-cycle WB-to-read forwarding on qa/qb; 0 = read ports show stored contents only.
- CNT_W, default 32: width of the writeback counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- clrn  input  1  reset, asynchronous, active-low. Clears all state immediately.
- wwreg  input  1  writeback enable from MEM/WB.
- wm2reg  input  1  writeback source select: 1 = memory data, 0 = ALU result.
- wmo  input  32  memory read data from MEM/WB.
- walu  input  32  ALU result from MEM/WB.
- wrn  input  5  destination register number.
- rna  input  5  read port A register number (rs, from ID).
- rnb  input  5  read port B register number (rt, from ID).
- qa  output  32  read port A data.
- qb  output  32  read port B data.
- wdi  output  32  selected writeback data, for the forwarding unit.
- wbcnt  output  CNT_W  count of committed register writes.

## Operation

- wdi = wm2reg ? wmo : walu. Combinational, valid every cycle, including when wwreg = 0.
- Commit condition: wwreg = 1 and wrn != 0. On the rising clk edge, register[wrn] <= wdi.
- Register 0 is hardwired to zero:
  - Writes to wrn = 0 are dropped.
  - Reads of register 0 return 0 regardless of bypass.
- Read ports are combinational, with port A and port B handled identically:
  - rna = 0: qa = 0.
  - Else, if BYPASS = 1, wwreg = 1 and wrn = rna: qa = wdi (bypass).
  - Else: qa = register[rna].
- Both ports may address the same register; both then return the same value, bypass included.
- wbcnt increments by 1 on each rising edge where the commit condition holds.
  - Writes to register 0 are not counted.
  - Wraps modulo 2^CNT_W: all-ones + 1 goes to 0, no saturation, no flag.
- No state machine. State is the 31 writable registers plus wbcnt.

## Timing

- Reset: while clrn = 0, all 31 registers = 0 and wbcnt = 0, asynchronously, with no clock needed.
  - With all registers zero, qa = qb = 0 unless the bypass path is active; bypass stays live during reset.
  - wdi follows its inputs during reset.
- Reset asserted in the same cycle as a commit: reset wins and no write or count occurs.
- First commit can occur on the first rising edge after clrn deasserts.
- Write latency: stored value visible via the storage path from the cycle after the commit edge. With BYPASS = 1, it is visible on qa/qb in the commit cycle itself (zero-cycle read-after-write).
- Back-to-back writes to the same register on consecutive cycles: each cycle's bypass returns that cycle's wdi, and the final stored value is the last write.
- wbcnt updates on the same edge as the register write.
- No handshake and no stall input. Upstream holds wwreg = 0 for bubbles.

## Test plan

- Reset and read: pulse clrn low mid-cycle, with no clk edge, after loading r5 = 0x1234_5678. Required: qa with rna = 5 reads 0 immediately, and wbcnt = 0.
- Source select and commit: wwreg = 1, wrn = 3, wm2reg = 1, wmo = 0xDEAD_BEEF, walu = 0x1111_1111; clock one edge, then wwreg = 0. Required: wdi = 0xDEAD_BEEF during the cycle; r3 = 0xDEAD_BEEF afterwards; wbcnt = 1. Repeat with wm2reg = 0: required r3 = 0x1111_1111.
- Bypass: BYPASS = 1, rna = rnb = 7, wwreg = 1, wrn = 7, walu = 0xA5A5_0001, wm2reg = 0. Required: qa = qb = 0xA5A5_0001 in the same cycle, before the edge. Same scenario with BYPASS = 0: required qa = qb = old r7 until after the edge.
- r0 protection: wwreg = 1, wrn = 0, walu = 0xFFFF_FFFF, rna = 0; clock. Required: qa = 0 both before and after the edge, and wbcnt unchanged.
- Counter wrap: with CNT_W = 4, perform 17 commits to r1. Required: wbcnt sequence ... 14, 15, 0, 1, and final wbcnt = 1.
- Reset versus write race: assert clrn low coincident with a commit edge for r9 = 0x55. Required: r9 = 0 and wbcnt = 0 after reset releases.

Source files
------------

// File: rtl/pipewbrf.sv
// pipewbrf: writeback stage with a 32x32 register file, two read ports,
// same-cycle write-to-read bypass and a retired-writeback counter.
module pipewbrf #(
    parameter bit          BYPASS = 1'b1,
    parameter int unsigned CNT_W  = 32
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic             wwreg,
    input  logic             wm2reg,
    input  logic [31:0]      wmo,
    input  logic [31:0]      walu,
    input  logic [4:0]       wrn,
    input  logic [4:0]       rna,
    input  logic [4:0]       rnb,
    output logic [31:0]      qa,
    output logic [31:0]      qb,
    output logic [31:0]      wdi,
    output logic [CNT_W-1:0] wbcnt
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned NREG   = 32;

    // Entry 0 is reset and never written, so it stays zero and is trimmed.
    logic [DATA_W-1:0] regs [NREG];
    logic              commit;
    logic              byp_a;
    logic              byp_b;

    // Writeback source mux, live every cycle regardless of wwreg.
    always_comb begin
        wdi = wm2reg ? wmo : walu;
    end

    // A write retires only when enabled and not aimed at r0.
    always_comb begin
        commit = wwreg && (wrn != 5'd0);
    end

    // Register file and counter; reset clears everything asynchronously.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            for (int i = 0; i < int'(NREG); i++) begin
                regs[i] <= '0;
            end
            wbcnt <= '0;
        end else if (commit) begin
            regs[wrn] <= wdi;
            wbcnt     <= wbcnt + CNT_W'(1);
        end
    end

    // Bypass selects: forward wdi when the WB destination matches a read port.
    always_comb begin
        byp_a = BYPASS && wwreg && (wrn == rna);
        byp_b = BYPASS && wwreg && (wrn == rnb);
    end

    // Read port A: r0 reads zero, then bypass, then stored contents.
    always_comb begin
        qa = '0;
        if (rna == 5'd0) begin
            qa = '0;
        end else if (byp_a) begin
            qa = wdi;
        end else begin
            qa = regs[rna];
        end
    end

    // Read port B: identical policy to port A.
    always_comb begin
        qb = '0;
        if (rnb == 5'd0) begin
            qb = '0;
        end else if (byp_b) begin
            qb = wdi;
        end else begin
            qb = regs[rnb];
        end
    end

endmodule

// File: tb/tb_pipewbrf.sv
// Testbench for pipewbrf: table-driven vectors plus reset/wrap/race sequences.
module tb_pipewbrf;

    logic        clk;
    logic        clrn;
    logic        wwreg;
    logic        wm2reg;
    logic [31:0] wmo;
    logic [31:0] walu;
    logic [4:0]  wrn;
    logic [4:0]  rna;
    logic [4:0]  rnb;

    logic [31:0] qa_a, qb_a, wdi_a, cnt_a;
    logic [31:0] qa_b, qb_b, wdi_b, cnt_b;
    logic [31:0] qa_c, qb_c, wdi_c;
    logic [3:0]  cnt_c;

    int checks;
    int failures;

    // Default configuration: bypass on, 32-bit counter.
    pipewbrf #(.BYPASS(1'b1), .CNT_W(32)) dut_a (
        .clk(clk), .clrn(clrn), .wwreg(wwreg), .wm2reg(wm2reg), .wmo(wmo),
        .walu(walu), .wrn(wrn), .rna(rna), .rnb(rnb),
        .qa(qa_a), .qb(qb_a), .wdi(wdi_a), .wbcnt(cnt_a)
    );

    // Bypass disabled.
    pipewbrf #(.BYPASS(1'b0), .CNT_W(32)) dut_b (
        .clk(clk), .clrn(clrn), .wwreg(wwreg), .wm2reg(wm2reg), .wmo(wmo),
        .walu(walu), .wrn(wrn), .rna(rna), .rnb(rnb),
        .qa(qa_b), .qb(qb_b), .wdi(wdi_b), .wbcnt(cnt_b)
    );

    // Narrow counter for wrap checking.
    pipewbrf #(.BYPASS(1'b1), .CNT_W(4)) dut_c (
        .clk(clk), .clrn(clrn), .wwreg(wwreg), .wm2reg(wm2reg), .wmo(wmo),
        .walu(walu), .wrn(wrn), .rna(rna), .rnb(rnb),
        .qa(qa_c), .qb(qb_c), .wdi(wdi_c), .wbcnt(cnt_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wwreg;
        logic        wm2reg;
        logic [31:0] wmo;
        logic [31:0] walu;
        logic [4:0]  wrn;
        logic [4:0]  rna;
        logic [4:0]  rnb;
        logic [31:0] exp_wdi;
        logic [31:0] exp_qa;
        logic [31:0] exp_qb;
        logic [31:0] exp_qa_nb;
        logic [31:0] exp_qb_nb;
        logic [31:0] exp_cnt;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic ww, input logic m2r, input logic [31:0] mo,
                         input logic [31:0] alu, input logic [4:0] wn,
                         input logic [4:0] ra, input logic [4:0] rb);
        wwreg  = ww;
        wm2reg = m2r;
        wmo    = mo;
        walu   = alu;
        wrn    = wn;
        rna    = ra;
        rnb    = rb;
    endtask

    initial begin
        checks   = 0;
        failures = 0;

        //        ww   m2r  wmo           walu          wrn   rna   rnb   wdi           qa            qb            qa_nb         qb_nb         cnt
        vecs[0] = '{1'b1, 1'b1, 32'hDEADBEEF, 32'h11111111, 5'd3, 5'd3, 5'd0, 32'hDEADBEEF, 32'hDEADBEEF, 32'h0,        32'h0,        32'h0,        32'd1};
        vecs[1] = '{1'b0, 1'b0, 32'h0,        32'h0,        5'd3, 5'd3, 5'd3, 32'h0,        32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'd1};
        vecs[2] = '{1'b1, 1'b0, 32'hDEADBEEF, 32'h11111111, 5'd3, 5'd3, 5'd5, 32'h11111111, 32'h11111111, 32'h0,        32'hDEADBEEF, 32'h0,        32'd2};
        vecs[3] = '{1'b1, 1'b0, 32'h0,        32'hA5A50001, 5'd7, 5'd7, 5'd7, 32'hA5A50001, 32'hA5A50001, 32'hA5A50001, 32'h0,        32'h0,        32'd3};
        vecs[4] = '{1'b0, 1'b1, 32'hCAFE0000, 32'h0,        5'd7, 5'd7, 5'd3, 32'hCAFE0000, 32'hA5A50001, 32'h11111111, 32'hA5A50001, 32'h11111111, 32'd3};
        vecs[5] = '{1'b1, 1'b0, 32'h0,        32'hFFFFFFFF, 5'd0, 5'd0, 5'd0, 32'hFFFFFFFF, 32'h0,        32'h0,        32'h0,        32'h0,        32'd3};
        vecs[6] = '{1'b0, 1'b0, 32'h0,        32'h0,        5'd0, 5'd0, 5'd7, 32'h0,        32'h0,        32'hA5A50001, 32'h0,        32'hA5A50001, 32'd3};
        vecs[7] = '{1'b1, 1'b0, 32'h0,        32'h00000001, 5'd7, 5'd7, 5'd3, 32'h00000001, 32'h00000001, 32'h11111111, 32'hA5A50001, 32'h11111111, 32'd4};
        vecs[8] = '{1'b1, 1'b0, 32'h0,        32'h00000002, 5'd7, 5'd7, 5'd3, 32'h00000002, 32'h00000002, 32'h11111111, 32'h00000001, 32'h11111111, 32'd5};
        vecs[9] = '{1'b0, 1'b0, 32'h0,        32'h0,        5'd7, 5'd7, 5'd7, 32'h0,        32'h00000002, 32'h00000002, 32'h00000002, 32'h00000002, 32'd5};

        // Reset state
        clrn = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd3, 5'd7);
        #1;
        chk("reset qa", qa_a, 32'h0);
        chk("reset qb", qb_a, 32'h0);
        chk("reset cnt", cnt_a, 32'h0);
        chk("reset cnt4", 32'(cnt_c), 32'h0);
        #1;
        clrn = 1'b1;

        // Table-driven vectors: combinational checks before the edge, counter after.
        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].wwreg, vecs[i].wm2reg, vecs[i].wmo, vecs[i].walu,
                  vecs[i].wrn, vecs[i].rna, vecs[i].rnb);
            #1;
            chk($sformatf("v%0d wdi", i), wdi_a, vecs[i].exp_wdi);
            chk($sformatf("v%0d qa", i), qa_a, vecs[i].exp_qa);
            chk($sformatf("v%0d qb", i), qb_a, vecs[i].exp_qb);
            chk($sformatf("v%0d qa_nb", i), qa_b, vecs[i].exp_qa_nb);
            chk($sformatf("v%0d qb_nb", i), qb_b, vecs[i].exp_qb_nb);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d cnt", i), cnt_a, vecs[i].exp_cnt);
            chk($sformatf("v%0d cnt_nb", i), cnt_b, vecs[i].exp_cnt);
        end

        // Load r5, then reset mid-cycle with no clock edge.
        drive(1'b1, 1'b0, 32'h0, 32'h12345678, 5'd5, 5'd5, 5'd5);
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd5, 5'd5, 5'd5);
        #1;
        chk("r5 loaded", qa_a, 32'h12345678);
        chk("r5 loaded nb", qb_b, 32'h12345678);
        chk("cnt before rst", cnt_a, 32'd6);
        #2;
        clrn = 1'b0;
        #1;
        chk("async rst qa", qa_a, 32'h0);
        chk("async rst qa nb", qa_b, 32'h0);
        chk("async rst cnt", cnt_a, 32'h0);
        chk("async rst cnt4", 32'(cnt_c), 32'h0);
        #1;
        clrn = 1'b1;

        // Counter wrap: 17 commits to r1 with the 4-bit counter.
        @(posedge clk);
        #1;
        drive(1'b1, 1'b0, 32'h0, 32'h0, 5'd1, 5'd1, 5'd0);
        for (int i = 0; i < 17; i++) begin
            walu = 32'(i + 100);
            @(posedge clk);
            #1;
            chk($sformatf("wrap cnt4 step%0d", i), 32'(cnt_c), 32'((i + 1) % 16));
        end
        wwreg = 1'b0;
        #1;
        chk("wrap final cnt4", 32'(cnt_c), 32'd1);
        chk("wrap cnt32", cnt_a, 32'd17);
        chk("wrap r1 last", qa_b, 32'd116);

        // Reset held across a commit edge for r9: reset wins.
        @(posedge clk);
        #1;
        drive(1'b1, 1'b0, 32'h0, 32'h00000055, 5'd9, 5'd9, 5'd9);
        #7;
        clrn = 1'b0;
        #1;
        chk("rst bypass live", qa_a, 32'h00000055);
        chk("rst no bypass", qa_b, 32'h0);
        chk("rst wdi live", wdi_a, 32'h00000055);
        @(posedge clk);
        #2;
        clrn = 1'b1;
        wwreg = 1'b0;
        #1;
        chk("race r9", qa_a, 32'h0);
        chk("race r9 nb", qb_b, 32'h0);
        chk("race cnt", cnt_a, 32'h0);
        chk("race cnt4", 32'(cnt_c), 32'h0);

        // First commit right after reset release.
        wwreg = 1'b1;
        @(posedge clk);
        #1;
        wwreg = 1'b0;
        #1;
        chk("post rst r9", qa_b, 32'h00000055);
        chk("post rst cnt", cnt_a, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
